// File: rtl/cr_frame_receiver.sv
// Remote-control frame receiver: decodes 8N1 frames from the rx line and
// turns a matching address/command into a single cr pulse with button hold-off.
module cr_frame_receiver #(
  parameter int          CLKS_PER_BIT = 48,
  parameter logic [3:0]  ADDR         = 4'hA,
  parameter logic [3:0]  CMD_CR       = 4'h1,
  parameter int          HOLDOFF      = 240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       cr,
  output logic       code_vld,
  output logic [7:0] rx_code,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HO_W  = $clog2(HOLDOFF + 1);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [HO_W-1:0]  HO_LOAD = HO_W'(HOLDOFF);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic             rx_meta_q, rx_s_q, rx_prev_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       code_q, code_d;
  logic             cr_q, cr_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic [HO_W-1:0]  holdoff_q, holdoff_d;
  logic             reload;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    code_d    = code_q;
    cr_d      = 1'b0;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    reload    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d   = S_START;
          clk_cnt_d = '0;
        end
      end
      S_START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            vld_d   = 1'b1;
            code_d  = shift_q;
            state_d = S_IDLE;
            if (shift_q == {ADDR, CMD_CR}) begin
              reload = 1'b1;
              cr_d   = (holdoff_q == '0);
            end
          end else begin
            err_d   = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every matching frame restarts the window, so a held button stays quiet.
    if (reload) begin
      holdoff_d = HO_LOAD;
    end else if (holdoff_q != '0) begin
      holdoff_d = holdoff_q - 1'b1;
    end else begin
      holdoff_d = holdoff_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      code_q    <= '0;
      cr_q      <= 1'b0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      holdoff_q <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      code_q    <= code_d;
      cr_q      <= cr_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      holdoff_q <= holdoff_d;
    end
  end

  assign cr        = cr_q;
  assign code_vld  = vld_q;
  assign frame_err = err_q;
  assign rx_code   = code_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cr_frame_receiver.sv
// Directed bench for cr_frame_receiver: table of whole frames plus hand-written
// glitch, mid-frame reset and back-to-back sequences.
module tb_cr_frame_receiver;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       cr, code_vld, frame_err, busy;
  logic [7:0] rx_code;

  cr_frame_receiver #(
    .CLKS_PER_BIT(CPB),
    .ADDR(4'hA),
    .CMD_CR(4'h1),
    .HOLDOFF(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .cr(cr),
    .code_vld(code_vld),
    .rx_code(rx_code),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters; "bad" counts cr without code_vld and frame_err with code_vld.
  int vld_n = 0, cr_n = 0, err_n = 0, bad_n = 0;
  always @(negedge clk) begin
    if (code_vld) vld_n <= vld_n + 1;
    if (cr) cr_n <= cr_n + 1;
    if (frame_err) err_n <= err_n + 1;
    if ((cr && !code_vld) || (frame_err && code_vld)) bad_n <= bad_n + 1;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold rx at v for n clock cycles; returns 1 time unit after a rising edge.
  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      rx = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(d[i], CPB);
    drive(stop, CPB);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         idle_before;
    int         low_after;
    int         exp_vld;
    int         exp_cr;
    int         exp_err;
    logic [7:0] exp_code;
  } vec_t;

  vec_t vecs[8];
  int b_v, b_c, b_e, b_b;

  initial begin
    vecs[0] = '{8'hA1, 1'b1, 10,  0,  1, 1, 0, 8'hA1}; // first match fires
    vecs[1] = '{8'hA1, 1'b1, 44,  0,  1, 0, 0, 8'hA1}; // inside hold-off
    vecs[2] = '{8'hA1, 1'b1, 44,  0,  1, 0, 0, 8'hA1}; // reloaded window still suppresses
    vecs[3] = '{8'hA1, 1'b1, 110, 0,  1, 1, 0, 8'hA1}; // window expired
    vecs[4] = '{8'hB1, 1'b1, 110, 0,  1, 0, 0, 8'hB1}; // wrong address
    vecs[5] = '{8'hA2, 1'b1, 4,   0,  1, 0, 0, 8'hA2}; // wrong command
    vecs[6] = '{8'hA1, 1'b0, 4,   40, 0, 0, 1, 8'hA2}; // stop low + break
    vecs[7] = '{8'hA1, 1'b1, 10,  0,  1, 1, 0, 8'hA1}; // B1/A2 did not reload hold-off

    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cr", cr, 0);
    check("reset_code_vld", code_vld, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_busy", busy, 0);
    check("reset_rx_code", rx_code, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int k = 0; k < 8; k++) begin
      drive(1'b1, vecs[k].idle_before);
      b_v = vld_n; b_c = cr_n; b_e = err_n; b_b = bad_n;
      send_frame(vecs[k].data, vecs[k].stop);
      if (vecs[k].low_after > 0) begin
        drive(1'b0, vecs[k].low_after);
        check("break_busy", busy, 1);
      end
      drive(1'b1, 6);
      $display("vec %0d data=%h stop=%0b vld=%0d cr=%0d err=%0d rx_code=%h busy=%0b",
               k, vecs[k].data, vecs[k].stop, vld_n - b_v, cr_n - b_c, err_n - b_e, rx_code, busy);
      check("vec_code_vld", vld_n - b_v, vecs[k].exp_vld);
      check("vec_cr", cr_n - b_c, vecs[k].exp_cr);
      check("vec_frame_err", err_n - b_e, vecs[k].exp_err);
      check("vec_rx_code", rx_code, vecs[k].exp_code);
      check("vec_exclusive", bad_n - b_b, 0);
      check("vec_busy_end", busy, 0);
    end

    // One-cycle glitch from idle must be discarded silently.
    b_v = vld_n; b_c = cr_n; b_e = err_n;
    drive(1'b0, 1);
    drive(1'b1, 12);
    $display("glitch vld=%0d cr=%0d err=%0d busy=%0b", vld_n - b_v, cr_n - b_c, err_n - b_e, busy);
    check("glitch_vld", vld_n - b_v, 0);
    check("glitch_cr", cr_n - b_c, 0);
    check("glitch_err", err_n - b_e, 0);
    check("glitch_busy", busy, 0);

    // Reset in the data bits of an A1 frame, then a full A1 must fire cr
    // even though the last cr was well inside the hold-off window.
    b_v = vld_n; b_c = cr_n; b_e = err_n;
    drive(1'b0, CPB);
    drive(1'b1, CPB);
    drive(1'b0, CPB);
    drive(1'b0, 2);
    reset = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_cr", cr, 0);
    check("midrst_code_vld", code_vld, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rx_code", rx_code, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 8);
    check("midrst_no_vld", vld_n - b_v, 0);
    check("midrst_no_err", err_n - b_e, 0);
    b_v = vld_n; b_c = cr_n;
    send_frame(8'hA1, 1'b1);
    drive(1'b1, 6);
    $display("after_reset vld=%0d cr=%0d rx_code=%h", vld_n - b_v, cr_n - b_c, rx_code);
    check("postrst_vld", vld_n - b_v, 1);
    check("postrst_cr", cr_n - b_c, 1);
    check("postrst_code", rx_code, 8'hA1);

    // Back-to-back frames with no idle gap between stop and next start.
    b_v = vld_n; b_c = cr_n; b_e = err_n;
    send_frame(8'hB1, 1'b1);
    send_frame(8'hA2, 1'b1);
    drive(1'b1, 6);
    $display("back_to_back vld=%0d cr=%0d err=%0d rx_code=%h", vld_n - b_v, cr_n - b_c, err_n - b_e, rx_code);
    check("b2b_vld", vld_n - b_v, 2);
    check("b2b_cr", cr_n - b_c, 0);
    check("b2b_err", err_n - b_e, 0);
    check("b2b_code", rx_code, 8'hA2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
